frame_resp_sched: RTL and testbench
===================================

# frame_resp_sched

Round-robin request/acknowledge scheduler that shares a single responder among NUM_REQ requesters. For each granted request it issues a one-cycle `start_event` and returns a one-cycle `ack` strictly inside a frame window of MIN_CKS..MAX_CKS cycles after the start. Its `start_event`/`ack` pair is, by construction, the stimulus that the OVL frame checkers in the assertion test suite expect to pass. It sits between the requester ports and the shared responder; the responder reports completion on `done`.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MIN_CKS, 2, earliest ack cycle after start_event (>=1)
- MAX_CKS, 4, latest ack cycle after start_event; 0 = unbounded; otherwise must be > MIN_CKS
- CNT_W, 4, frame counter width; must hold max(MIN_CKS, MAX_CKS)
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  arbitration enable; sampled in IDLE only
- req  in  NUM_REQ  level requests, held until acked
- done  in  1  responder completion, single-cycle or level
- grant  out  NUM_REQ  one-hot owner, held from start through ack
- start_event  out  1  one-cycle pulse, first grant cycle
- ack  out  NUM_REQ  one-cycle pulse to granted requester
- busy  out  1  frame in progress
- timeout_err  out  1  one-cycle pulse coincident with a forced ack
- frame_cnt  out  CNT_W  cycles since start_event
- timeout_count  out  8  saturating forced-ack count

## Operation
- FSM states: IDLE, WAIT_MIN, WINDOW, ACK.
- IDLE: if enable && |req, pick the first set req at or after rr_ptr (wrapping) -> WAIT_MIN; register grant, start_event=1, frame_cnt=0.
- Each cycle after the start, frame_cnt increments; it saturates at all-ones.
- WAIT_MIN (frame_cnt < MIN_CKS): a done sampled high sets early_done. At frame_cnt==MIN_CKS-1: -> ACK if early_done or done, else -> WINDOW.
- WINDOW: done sampled high -> ACK. If MAX_CKS!=0 and frame_cnt==MAX_CKS-1 with no done -> ACK with forced flag.
- ACK: ack[owner]=1 for one cycle; timeout_err=1 if forced; rr_ptr = owner+1 mod NUM_REQ; -> IDLE. grant is held through this cycle.
- Net effect: ack occurs at frame_cnt = max(MIN_CKS, d+1), where d is the frame_cnt at the first done sample; capped at MAX_CKS.
- done sampled in IDLE or ACK is ignored.
- A requester that drops req mid-frame is still acked.
- enable low does not abort a frame in flight.
- busy = (state != IDLE).

## Timing
- Reset values: grant=0, start_event=0, ack=0, busy=0, timeout_err=0, frame_cnt=0, timeout_count=0, rr_ptr=0, early_done=0, state=IDLE.
- Reset asserted mid-frame: every output is 0 at the next edge; no ack is issued.
- Request-to-start latency: 1 cycle (req sampled at edge N gives start_event in cycle N+1).
- Back-to-back frames: the next start_event comes 1 cycle after the ack cycle (one IDLE cycle between frames).
- ack is never in the start_event cycle (MIN_CKS>=1).
- Simultaneous requests: rotating priority; no requester waits more than NUM_REQ-1 frames.

## Configuration
- FRAME_SCHED_STATS_EN defined: timeout_count increments on each timeout_err pulse and saturates at 255. It clears only on reset.
- FRAME_SCHED_STATS_EN undefined: timeout_count is tied to 0 and the counter logic is not generated. All other behaviour is identical.

## Test plan
- Reset held 5 cycles with req=4'b1111: all outputs 0, no start_event; release reset -> grant=4'b0001 and start_event one cycle later.
- req[2] only, done pulsed at frame_cnt=0 (MIN=2, MAX=4): ack[2] at frame_cnt=2, timeout_err=0.
- req[1], done at frame_cnt=3: ack[1] at frame_cnt=4.
- done never asserted: ack at frame_cnt=4 with timeout_err=1; timeout_count=1 with macro, 0 without.
- req=4'b1111 held and done held high: grants in order 0,1,2,3,0; each frame is 4 cycles (1 start + window + ack + idle) with start_events 4 cycles apart.
- MAX_CKS=0, done delayed 10 cycles: no timeout; ack at frame_cnt=11. Reset at frame_cnt=1: no ack, and a new grant starts from requester 0.

Source files
------------

// File: rtl/frame_resp_sched.sv
// ============================================================================
//  Module   : frame_resp_sched
//  Purpose  : Round-robin scheduler sharing one responder among NUM_REQ
//             requesters; acks each grant inside a MIN_CKS..MAX_CKS window.
//             Optional macro FRAME_SCHED_STATS_EN enables the forced-ack count.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_resp_sched #(
    parameter int NUM_REQ = 4,
    parameter int MIN_CKS = 2,
    parameter int MAX_CKS = 4,
    parameter int CNT_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic               start_event,
    output logic [NUM_REQ-1:0] ack,
    output logic               busy,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic [7:0]         timeout_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_wait_min = 2'd1;
    localparam logic [1:0] c_window   = 2'd2;
    localparam logic [1:0] c_ack      = 2'd3;

    localparam logic [CNT_W-1:0] c_min_m1  = CNT_W'(MIN_CKS - 1);
    localparam logic [CNT_W-1:0] c_max_m1  = CNT_W'(MAX_CKS - 1);
    localparam logic [PTR_W-1:0] c_ptr_top = PTR_W'(NUM_REQ - 1);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               early_done_q, early_done_d;
    logic               forced_q, forced_d;
    logic               start_q, start_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic               w_found;
    logic [PTR_W-1:0]   w_pick;
    int                 w_idx;

    // Rotating search: first asserted request at or after rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = PTR_W'(w_idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        early_done_d = early_done_q;
        forced_d     = forced_q;
        start_d      = 1'b0;
        frame_cnt_d  = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + CNT_W'(1);

        case (state_q)
            c_idle: begin
                if (enable && w_found) begin
                    state_d      = c_wait_min;
                    grant_d      = NUM_REQ'(1) << w_pick;
                    owner_d      = w_pick;
                    start_d      = 1'b1;
                    frame_cnt_d  = '0;
                    early_done_d = 1'b0;
                    forced_d     = 1'b0;
                end
            end
            c_wait_min: begin
                // A done seen before the minimum is remembered and honoured at MIN_CKS.
                if (frame_cnt_q == c_min_m1) begin
                    state_d = (early_done_q || done) ? c_ack : c_window;
                end else if (done) begin
                    early_done_d = 1'b1;
                end
            end
            c_window: begin
                if (done) begin
                    state_d = c_ack;
                end else if ((MAX_CKS != 0) && (frame_cnt_q == c_max_m1)) begin
                    state_d  = c_ack;
                    forced_d = 1'b1;
                end
            end
            c_ack: begin
                state_d      = c_idle;
                grant_d      = '0;
                early_done_d = 1'b0;
                forced_d     = 1'b0;
                rr_ptr_d     = (owner_q == c_ptr_top) ? '0 : owner_q + PTR_W'(1);
            end
            default: state_d = c_idle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= c_idle;
            grant_q      <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            early_done_q <= 1'b0;
            forced_q     <= 1'b0;
            start_q      <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            early_done_q <= early_done_d;
            forced_q     <= forced_d;
            start_q      <= start_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign start_event = start_q;
    assign ack         = (state_q == c_ack) ? grant_q : '0;
    assign busy        = (state_q != c_idle);
    assign timeout_err = (state_q == c_ack) && forced_q;
    assign frame_cnt   = frame_cnt_q;

`ifdef FRAME_SCHED_STATS_EN
    logic [7:0] timeout_count_q, timeout_count_d;

    always_comb begin
        timeout_count_d = timeout_count_q;
        if (timeout_err && (timeout_count_q != 8'hFF)) begin
            timeout_count_d = timeout_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_count_q <= 8'd0;
        end else begin
            timeout_count_q <= timeout_count_d;
        end
    end

    assign timeout_count = timeout_count_q;
`else
    assign timeout_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_resp_sched.sv
// ============================================================================
//  Module   : tb_frame_resp_sched
//  Purpose  : Directed self-checking bench for frame_resp_sched (bounded and
//             unbounded window instances).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_frame_resp_sched;

    logic       clock;
    logic       reset, enable, done;
    logic [3:0] req;
    logic [3:0] grant, ack;
    logic       start_event, busy, timeout_err;
    logic [3:0] frame_cnt;
    logic [7:0] timeout_count;

    logic       reset2, enable2, done2;
    logic [3:0] req2;
    logic [3:0] grant2, ack2;
    logic       start_event2, busy2, timeout_err2;
    logic [3:0] frame_cnt2;
    logic [7:0] timeout_count2;

    int total;
    int bad;

    frame_resp_sched #(.NUM_REQ(4), .MIN_CKS(2), .MAX_CKS(4), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .enable(enable), .req(req), .done(done),
        .grant(grant), .start_event(start_event), .ack(ack), .busy(busy),
        .timeout_err(timeout_err), .frame_cnt(frame_cnt), .timeout_count(timeout_count)
    );

    frame_resp_sched #(.NUM_REQ(4), .MIN_CKS(2), .MAX_CKS(0), .CNT_W(4)) dut_unb (
        .clock(clock), .reset(reset2), .enable(enable2), .req(req2), .done(done2),
        .grant(grant2), .start_event(start_event2), .ack(ack2), .busy(busy2),
        .timeout_err(timeout_err2), .frame_cnt(frame_cnt2), .timeout_count(timeout_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; req = 4'b1111; done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({grant, ack, start_event, busy, timeout_err, frame_cnt, timeout_count} !== 23'd0) begin
                bad++;
                $display("FAIL reset_outputs cycle=%0d got grant=%b ack=%b start=%b busy=%b terr=%b cnt=%0d tcnt=%0d want all 0",
                         i, grant, ack, start_event, busy, timeout_err, frame_cnt, timeout_count);
            end
        end
        reset = 1'b0;
        tick();
        total++;
        if (grant !== 4'b0001 || start_event !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_grant got grant=%b start=%b want grant=0001 start=1", grant, start_event);
        end
        done = 1'b1;
        for (int n = 0; n < 20 && ack === 4'b0000; n++) tick();
        total++;
        if (ack !== 4'b0001) begin
            bad++;
            $display("FAIL reset_release_ack got ack=%b want 0001", ack);
        end
        req = 4'b0000; done = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_enable_low();
        enable = 1'b0; req = 4'b0001;
        tick(); tick();
        total++;
        if (busy !== 1'b0 || start_event !== 1'b0) begin
            bad++;
            $display("FAIL enable_low got busy=%b start=%b want 0 0", busy, start_event);
        end
        req = 4'b0000; enable = 1'b1;
        tick();
    endtask

    task automatic test_done_early();
        req = 4'b0100;
        tick();
        total++;
        if (grant !== 4'b0100 || start_event !== 1'b1 || frame_cnt !== 4'd0) begin
            bad++;
            $display("FAIL early_start got grant=%b start=%b cnt=%0d want 0100 1 0", grant, start_event, frame_cnt);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int n = 0; n < 20 && ack === 4'b0000; n++) tick();
        total++;
        if (ack !== 4'b0100 || frame_cnt !== 4'd2 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL early_ack got ack=%b cnt=%0d terr=%b want 0100 2 0", ack, frame_cnt, timeout_err);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_done_late();
        req = 4'b0010;
        tick();
        total++;
        if (grant !== 4'b0010 || start_event !== 1'b1) begin
            bad++;
            $display("FAIL late_start got grant=%b start=%b want 0010 1", grant, start_event);
        end
        tick(); tick(); tick();
        total++;
        if (frame_cnt !== 4'd3 || ack !== 4'b0000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL late_window got cnt=%0d ack=%b busy=%b want 3 0000 1", frame_cnt, ack, busy);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        total++;
        if (ack !== 4'b0010 || frame_cnt !== 4'd4 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL late_ack got ack=%b cnt=%0d terr=%b want 0010 4 0", ack, frame_cnt, timeout_err);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        logic [7:0] exp_tc;
`ifdef FRAME_SCHED_STATS_EN
        exp_tc = 8'd1;
`else
        exp_tc = 8'd0;
`endif
        req = 4'b1000;
        tick();
        for (int n = 0; n < 20 && ack === 4'b0000; n++) tick();
        total++;
        if (ack !== 4'b1000 || frame_cnt !== 4'd4 || timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_ack got ack=%b cnt=%0d terr=%b want 1000 4 1", ack, frame_cnt, timeout_err);
        end
        req = 4'b0000;
        tick();
        total++;
        if (timeout_count !== exp_tc || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_count got tcnt=%0d terr=%b want %0d 0", timeout_count, timeout_err, exp_tc);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_grant [5];
        exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111; done = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            total++;
            if (start_event !== 1'b1 || grant !== exp_grant[k]) begin
                bad++;
                $display("FAIL b2b_start frame=%0d got start=%b grant=%b want 1 %b", k, start_event, grant, exp_grant[k]);
            end
            tick(); tick();
            total++;
            if (ack !== exp_grant[k] || start_event !== 1'b0) begin
                bad++;
                $display("FAIL b2b_ack frame=%0d got ack=%b start=%b want %b 0", k, ack, start_event, exp_grant[k]);
            end
            if (k == 4) req = 4'b0000;
            tick(); tick();
        end
        done = 1'b0;
        total++;
        if (busy !== 1'b0 || start_event !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end got busy=%b start=%b want 0 0", busy, start_event);
        end
    endtask

    task automatic test_unbounded();
        int early_acks;
        early_acks = 0;
        reset2 = 1'b0; enable2 = 1'b1; req2 = 4'b0100; done2 = 1'b0;
        tick();
        total++;
        if (grant2 !== 4'b0100 || start_event2 !== 1'b1) begin
            bad++;
            $display("FAIL unb_start got grant=%b start=%b want 0100 1", grant2, start_event2);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack2 !== 4'b0000 || timeout_err2 !== 1'b0) early_acks++;
        end
        total++;
        if (early_acks != 0 || frame_cnt2 !== 4'd10 || busy2 !== 1'b1) begin
            bad++;
            $display("FAIL unb_wait got early_acks=%0d cnt=%0d busy=%b want 0 10 1", early_acks, frame_cnt2, busy2);
        end
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        total++;
        if (ack2 !== 4'b0100 || frame_cnt2 !== 4'd11 || timeout_err2 !== 1'b0) begin
            bad++;
            $display("FAIL unb_ack got ack=%b cnt=%0d terr=%b want 0100 11 0", ack2, frame_cnt2, timeout_err2);
        end
        req2 = 4'b1111;
        tick();
        tick();
        total++;
        if (grant2 !== 4'b1000 || start_event2 !== 1'b1) begin
            bad++;
            $display("FAIL unb_rr got grant=%b start=%b want 1000 1", grant2, start_event2);
        end
        tick();
        reset2 = 1'b1;
        tick();
        total++;
        if ({grant2, ack2, start_event2, busy2, timeout_err2, frame_cnt2, timeout_count2} !== 23'd0) begin
            bad++;
            $display("FAIL unb_midreset got grant=%b ack=%b start=%b busy=%b terr=%b cnt=%0d want all 0",
                     grant2, ack2, start_event2, busy2, timeout_err2, frame_cnt2);
        end
        reset2 = 1'b0;
        tick();
        total++;
        if (grant2 !== 4'b0001 || start_event2 !== 1'b1) begin
            bad++;
            $display("FAIL unb_restart got grant=%b start=%b want 0001 1", grant2, start_event2);
        end
        done2 = 1'b1;
        for (int n = 0; n < 20 && ack2 === 4'b0000; n++) tick();
        req2 = 4'b0000; done2 = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset2 = 1'b1; enable2 = 1'b0; req2 = 4'b0000; done2 = 1'b0;
        test_reset();
        test_enable_low();
        test_done_early();
        test_done_late();
        test_timeout();
        test_back_to_back();
        test_unbounded();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
